// File: rtl/ifetch_queue.sv
// Instruction fetch unit: single-word fetch from memory, JAL/B-type next-PC pre-decode,
// and a first-word-fall-through queue of {ins, pc, prediction} for decode/issue.
module ifetch_queue #(
    parameter int          QUEUE_DEPTH = 8,
    parameter int          PTR_W       = 3,
    parameter int          BR_PREDICT  = 1,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    output logic             mem_req_valid,
    output logic [31:0]      mem_req_addr,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_ins,
    input  logic             flush,
    input  logic [31:0]      flush_pc,
    input  logic             deq_ready,
    output logic             out_valid,
    output logic [31:0]      out_ins,
    output logic [31:0]      out_pc,
    output logic             out_pred_taken,
    output logic [31:0]      out_pred_pc,
    output logic [PTR_W:0]   queue_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DROP} state_t;

    state_t             state, state_next;
    logic [31:0]        pc, req_addr;
    logic [PTR_W-1:0]   head, tail;
    logic [PTR_W:0]     count, count_next;
    logic               enq, deq, can_fetch;

    logic [31:0]            ins_mem     [QUEUE_DEPTH];
    logic [31:0]            pc_mem      [QUEUE_DEPTH];
    logic [31:0]            pred_pc_mem [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] taken_mem;

    logic [6:0]  opcode;
    logic [31:0] j_imm, b_imm, pred_next;
    logic        pred_taken;

    // The response always answers req_addr, so that is the PC the prediction is based on.
    always_comb begin
        opcode     = mem_resp_ins[6:0];
        j_imm      = {{12{mem_resp_ins[31]}}, mem_resp_ins[19:12], mem_resp_ins[20],
                      mem_resp_ins[30:21], 1'b0};
        b_imm      = {{20{mem_resp_ins[31]}}, mem_resp_ins[7], mem_resp_ins[30:25],
                      mem_resp_ins[11:8], 1'b0};
        pred_taken = 1'b0;
        pred_next  = req_addr + 32'd4;
        if (opcode == 7'b1101111) begin
            pred_taken = 1'b1;
            pred_next  = req_addr + j_imm;
        end else if (opcode == 7'b1100011 && BR_PREDICT != 0 && mem_resp_ins[31]) begin
            pred_taken = 1'b1;
            pred_next  = req_addr + b_imm;
        end
    end

    assign deq        = out_valid && deq_ready;
    assign enq        = (state == ST_WAIT) && mem_resp_valid && !flush;
    assign count_next = count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    assign can_fetch  = count < FULL_COUNT;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else if (rdy)
            state <= state_next;
    end

    // A response arriving together with a flush completes the old request even from DROP,
    // so there is nothing left outstanding to wait for.
    always_comb begin
        state_next = state;
        if (flush) begin
            if (state != ST_IDLE)
                state_next = mem_resp_valid ? ST_IDLE : ST_DROP;
        end else begin
            case (state)
                ST_IDLE: if (can_fetch) state_next = ST_WAIT;
                ST_WAIT: if (mem_resp_valid)
                             state_next = (count_next < FULL_COUNT) ? ST_WAIT : ST_IDLE;
                ST_DROP: if (mem_resp_valid) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_valid  = (state == ST_WAIT) || (state == ST_DROP);
        mem_req_addr   = req_addr;
        out_valid      = (count != '0);
        queue_count    = count;
        out_ins        = out_valid ? ins_mem[head]     : 32'h0;
        out_pc         = out_valid ? pc_mem[head]      : 32'h0;
        out_pred_pc    = out_valid ? pred_pc_mem[head] : 32'h0;
        out_pred_taken = out_valid ? taken_mem[head]   : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_addr <= 32'h0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (rdy) begin
            if (flush) begin
                pc    <= flush_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                count <= count_next;
                if (deq)
                    head <= head + PTR_W'(1);
                if (enq) begin
                    tail <= tail + PTR_W'(1);
                    pc   <= pred_next;
                    if (count_next < FULL_COUNT)
                        req_addr <= pred_next;
                end else if (state == ST_IDLE && can_fetch) begin
                    req_addr <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && enq) begin
            ins_mem[tail]     <= mem_resp_ins;
            pc_mem[tail]      <= req_addr;
            pred_pc_mem[tail] <= pred_next;
            taken_mem[tail]   <= pred_taken;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: latency-programmable memory model, a table of
// pre-decode vectors, and hand-written sequences for fill, flush and rdy-stall corners.
module tb_ifetch_queue;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, deq_ready;
    logic [31:0] flush_pc;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_ins;

    logic        mem_req_valid, out_valid, out_pred_taken;
    logic [31:0] mem_req_addr, out_ins, out_pc, out_pred_pc;
    logic [3:0]  queue_count;

    logic        nt_req_valid, nt_out_valid, nt_pred_taken;
    logic [31:0] nt_req_addr, nt_out_ins, nt_out_pc, nt_pred_pc;
    logic [3:0]  nt_count;

    int checks = 0;
    int passes = 0;

    logic [31:0] rom [logic [31:0]];
    logic [31:0] req_log [$];
    int          wait_cnt;
    int          mem_lat = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exp_taken;
        logic [31:0] exp_next;
        logic        exp_taken_nt;
        logic [31:0] exp_next_nt;
    } vec_t;

    vec_t vecs [7];

    ifetch_queue #(.QUEUE_DEPTH(8), .PTR_W(3), .BR_PREDICT(1), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ins(mem_resp_ins),
        .flush(flush), .flush_pc(flush_pc), .deq_ready(deq_ready),
        .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
        .out_pred_taken(out_pred_taken), .out_pred_pc(out_pred_pc),
        .queue_count(queue_count)
    );

    // Not-taken predictor twin; it sees the same stimulus and diverges only on backward branches.
    ifetch_queue #(.QUEUE_DEPTH(8), .PTR_W(3), .BR_PREDICT(0), .RESET_PC(32'h0)) dut_nt (
        .clk(clk), .rst(rst), .rdy(rdy),
        .mem_req_valid(nt_req_valid), .mem_req_addr(nt_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ins(mem_resp_ins),
        .flush(flush), .flush_pc(flush_pc), .deq_ready(deq_ready),
        .out_valid(nt_out_valid), .out_ins(nt_out_ins), .out_pc(nt_out_pc),
        .out_pred_taken(nt_pred_taken), .out_pred_pc(nt_pred_pc),
        .queue_count(nt_count)
    );

    always #5 clk = ~clk;

    // Memory answers after mem_lat idle cycles; it freezes with rdy and resets with rst.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mem_resp_valid = 1'b0;
            mem_resp_ins   = 32'h0;
            wait_cnt       = 0;
            req_log.delete();
        end else if (rdy) begin
            if (mem_req_valid) begin
                if (wait_cnt >= mem_lat) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_ins   = rom.exists(mem_req_addr) ? rom[mem_req_addr] : NOP;
                    req_log.push_back(mem_req_addr);
                    wait_cnt       = 0;
                end else begin
                    mem_resp_valid = 1'b0;
                    wait_cnt++;
                end
            end else begin
                mem_resp_valid = 1'b0;
                wait_cnt       = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        else
            passes++;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        flush     = 1'b0;
        deq_ready = 1'b0;
        rdy       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Redirect to the vector's PC and wait for its entry to reach the queue head.
    task automatic applyStimulus(input vec_t v);
        rom[v.pc] = v.ins;
        flush     = 1'b1;
        flush_pc  = v.pc;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_empties_queue", {31'h0, out_valid}, 32'h0);
        for (int i = 0; i < 10 && !out_valid; i++)
            @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{32'h10,       32'h0200006F, 1'b1, 32'h30,  1'b1, 32'h30};
        vecs[1] = '{32'h40,       32'hFE000CE3, 1'b1, 32'h38,  1'b0, 32'h44};
        vecs[2] = '{32'h80,       32'h00000863, 1'b0, 32'h84,  1'b0, 32'h84};
        vecs[3] = '{32'h90,       32'h000080E7, 1'b0, 32'h94,  1'b0, 32'h94};
        vecs[4] = '{32'h200,      32'hF01FF06F, 1'b1, 32'h100, 1'b1, 32'h100};
        vecs[5] = '{32'hFFFFFFF0, 32'h0200006F, 1'b1, 32'h10,  1'b1, 32'h10};
        vecs[6] = '{32'h300,      NOP,          1'b0, 32'h304, 1'b0, 32'h304};

        flush_pc = 32'h0;
        mem_lat  = 0;

        // Reset state while rst is held.
        rst = 1'b1; flush = 1'b0; deq_ready = 1'b0; rdy = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_req_valid",  {31'h0, mem_req_valid},  32'h0);
        checkOutput("reset_req_addr",   mem_req_addr,            32'h0);
        checkOutput("reset_out_valid",  {31'h0, out_valid},      32'h0);
        checkOutput("reset_count",      {28'h0, queue_count},    32'h0);
        checkOutput("reset_out_ins",    out_ins,                 32'h0);
        checkOutput("reset_out_pc",     out_pc,                  32'h0);
        checkOutput("reset_pred_taken", {31'h0, out_pred_taken}, 32'h0);
        checkOutput("reset_pred_pc",    out_pred_pc,             32'h0);
        rst = 1'b0;

        // Fill with a 1-cycle memory and no consumer.
        @(negedge clk);
        checkOutput("first_req_valid", {31'h0, mem_req_valid}, 32'h1);
        checkOutput("first_req_addr",  mem_req_addr,           32'h0);
        repeat (11) @(negedge clk);
        checkOutput("fill_req_total", req_log.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("fill_req_addr_%0d", i),
                        (i < req_log.size()) ? req_log[i] : 32'hDEADBEEF, 32'(4 * i));
        checkOutput("fill_req_valid_low", {31'h0, mem_req_valid}, 32'h0);
        checkOutput("fill_count",         {28'h0, queue_count},   32'd8);
        checkOutput("fill_head_pc",       out_pc,                 32'h0);
        checkOutput("fill_head_pred_pc",  out_pred_pc,            32'h4);

        // One dequeue from a full queue frees a slot and triggers the next fetch.
        deq_ready = 1'b1;
        @(negedge clk);
        deq_ready = 1'b0;
        checkOutput("deq1_count",     {28'h0, queue_count},   32'd7);
        checkOutput("deq1_head_pc",   out_pc,                 32'h4);
        checkOutput("deq1_req_idle",  {31'h0, mem_req_valid}, 32'h0);
        @(negedge clk);
        checkOutput("refill_req_valid", {31'h0, mem_req_valid}, 32'h1);
        checkOutput("refill_req_addr",  mem_req_addr,           32'h20);
        @(negedge clk);
        checkOutput("refill_count",     {28'h0, queue_count},   32'd8);

        // Stream out across the pointer wrap while fetching continues.
        deq_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("stream_pc_%0d", k), out_pc, 32'(4 + 4 * k));
            @(negedge clk);
        end
        deq_ready = 1'b0;

        // Pre-decode vectors, each started by a redirect.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v]);
            checkOutput($sformatf("v%0d_out_valid", v),  {31'h0, out_valid},      32'h1);
            checkOutput($sformatf("v%0d_out_pc", v),     out_pc,                  vecs[v].pc);
            checkOutput($sformatf("v%0d_out_ins", v),    out_ins,                 vecs[v].ins);
            checkOutput($sformatf("v%0d_taken", v),      {31'h0, out_pred_taken}, {31'h0, vecs[v].exp_taken});
            checkOutput($sformatf("v%0d_pred_pc", v),    out_pred_pc,             vecs[v].exp_next);
            checkOutput($sformatf("v%0d_next_req", v),   mem_req_addr,            vecs[v].exp_next);
            checkOutput($sformatf("v%0d_nt_taken", v),   {31'h0, nt_pred_taken},  {31'h0, vecs[v].exp_taken_nt});
            checkOutput($sformatf("v%0d_nt_pred_pc", v), nt_pred_pc,              vecs[v].exp_next_nt);
            checkOutput($sformatf("v%0d_nt_next_req", v), nt_req_addr,            vecs[v].exp_next_nt);
        end

        // Flush while waiting; the stale response arrives later and must be dropped.
        mem_lat = 3;
        doReset();
        for (int i = 0; i < 10 && !mem_req_valid; i++)
            @(negedge clk);
        checkOutput("drop_req_seen", {31'h0, mem_req_valid}, 32'h1);
        flush    = 1'b1;
        flush_pc = 32'h100;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("drop_keeps_req",  {31'h0, mem_req_valid}, 32'h1);
        checkOutput("drop_keeps_addr", mem_req_addr,           32'h0);
        for (int i = 0; i < 10 && mem_req_valid; i++)
            @(negedge clk);
        checkOutput("drop_req_released", {31'h0, mem_req_valid}, 32'h0);
        checkOutput("drop_no_enqueue",   {31'h0, out_valid},     32'h0);
        checkOutput("drop_count",        {28'h0, queue_count},   32'h0);
        @(negedge clk);
        checkOutput("drop_redirect_valid", {31'h0, mem_req_valid}, 32'h1);
        checkOutput("drop_redirect_addr",  mem_req_addr,           32'h100);
        for (int i = 0; i < 10 && !out_valid; i++)
            @(negedge clk);
        checkOutput("drop_first_entry_pc", out_pc, 32'h100);

        // Flush in the same cycle as the response.
        mem_lat = 1;
        doReset();
        for (int i = 0; i < 10 && !mem_resp_valid; i++)
            @(negedge clk);
        checkOutput("same_cycle_resp_seen", {31'h0, mem_resp_valid}, 32'h1);
        flush    = 1'b1;
        flush_pc = 32'h700;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("same_cycle_idle",      {31'h0, mem_req_valid}, 32'h0);
        checkOutput("same_cycle_out_valid", {31'h0, out_valid},     32'h0);
        checkOutput("same_cycle_count",     {28'h0, queue_count},   32'h0);
        @(negedge clk);
        checkOutput("same_cycle_req_valid", {31'h0, mem_req_valid}, 32'h1);
        checkOutput("same_cycle_req_addr",  mem_req_addr,           32'h700);

        // rdy low mid-WAIT freezes everything, including a flush.
        mem_lat = 2;
        doReset();
        for (int i = 0; i < 30 && queue_count != 4'd2; i++)
            @(negedge clk);
        checkOutput("stall_setup_count", {28'h0, queue_count}, 32'd2);
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            flush    = (c == 2);
            flush_pc = 32'h900;
            @(negedge clk);
            checkOutput($sformatf("stall%0d_count", c),     {28'h0, queue_count},   32'd2);
            checkOutput($sformatf("stall%0d_req_valid", c), {31'h0, mem_req_valid}, 32'h1);
            checkOutput($sformatf("stall%0d_req_addr", c),  mem_req_addr,           32'h8);
            checkOutput($sformatf("stall%0d_out_pc", c),    out_pc,                 32'h0);
        end
        flush = 1'b0;
        rdy   = 1'b1;
        for (int i = 0; i < 10 && queue_count != 4'd3; i++)
            @(negedge clk);
        checkOutput("resume_count",    {28'h0, queue_count}, 32'd3);
        checkOutput("resume_head_pc",  out_pc,               32'h0);
        checkOutput("resume_next_req", mem_req_addr,         32'hC);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
